mux_arb_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with built-in arbitration and valid/ready handshakes, the sequential successor to the combinational 2:1 MUX. Each cycle it selects one requesting input channel, by fixed priority or round-robin, and captures that channel's data into a one-entry output register. It sits between multiple producers and a single consumer, such as a shared bus or result port.

---
 rtl/mux_arb_rr_if.sv | 40 ++++
 rtl/mux_arb_rr.sv | 129 ++++++++++++
 tb/tb_mux_arb_rr.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_rr_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// The slave view belongs to the arbiter. The master view is the environment
// that drives requests and consumes the output register.
interface mux_arb_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic             mode;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_ready;

    modport master (
        output mode,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    modport slave (
        input  mode,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );
endinterface

// File: rtl/mux_arb_rr.sv
// N-channel registered multiplexer with fixed-priority / round-robin arbitration.
// One winning channel per cycle is captured into a single-entry output register.
// in_ready depends only on in_valid, mode, out_ready, rst and internal state,
// never on in_data.
module mux_arb_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    mux_arb_rr_if.slave  bus
);
    localparam int SW = $clog2(N);
    // One extra bit so that ptr + offset can exceed N-1 before wrapping.
    localparam int CW = SW + 1;

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_any;
    logic [SW-1:0] w_idx;
    logic [CW-1:0] w_cand;
    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_ptr_next;
    logic [W-1:0]  w_data;

    // The register can take a new word when it is empty or being drained now.
    assign w_load_en = ~r_out_valid | bus.out_ready;

    // Search requesters from 0 (fixed) or from ptr with wrap (round-robin).
    always_comb begin
        w_any  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.mode) begin
                w_cand = {1'b0, r_ptr} + CW'(k);
                if (w_cand >= CW'(N)) begin
                    w_cand = w_cand - CW'(N);
                end else begin
                    w_cand = w_cand;
                end
            end else begin
                w_cand = CW'(k);
            end
            if (!w_any && bus.in_valid[w_cand[SW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_cand[SW-1:0];
            end else begin
                w_any = w_any;
                w_idx = w_idx;
            end
        end
    end

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        w_grant = '0;
        if (w_any) begin
            w_grant[w_idx] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    // Accept is suppressed during reset and while the output is stalled.
    always_comb begin
        bus.in_ready = '0;
        if (rst) begin
            bus.in_ready = '0;
        end else if (w_load_en) begin
            bus.in_ready = w_grant;
        end else begin
            bus.in_ready = '0;
        end
    end

    // Pointer moves to the channel after the winner, wrapping N-1 to 0.
    always_comb begin
        w_ptr_next = '0;
        if (w_idx == SW'(N - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + SW'(1);
        end
    end

    // Select the winning channel's word.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == w_idx) begin
                w_data = bus.in_data[k*W +: W];
            end else begin
                w_data = w_data;
            end
        end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en && w_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_sel   <= w_idx;
            r_ptr       <= w_ptr_next;
        end else if (w_load_en) begin
            // Drained with nothing to replace it: data and sel keep last word.
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_sel   <= r_out_sel;
            r_ptr       <= r_ptr;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench for mux_arb_rr: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_mux_arb_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arb_rr_if #(.N(N), .W(W)) bus();
    mux_arb_rr #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            m_ptr = 0;
    logic          m_ov  = 1'b0;
    logic [W-1:0]  m_od  = '0;
    logic [SW-1:0] m_os  = '0;

    // Winner: first requester scanning from 0 (fixed) or from ptr modulo N.
    function automatic logic [N-1:0] m_grant(input logic md, input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < N; k++) begin
            idx = md ? ((p + k) % N) : k;
            if (v[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [N-1:0] m_ready();
        if (rst) return '0;
        if (m_ov && !bus.out_ready) return '0;
        return m_grant(bus.mode, bus.in_valid, m_ptr);
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic [N-1:0] g;
        @(posedge clk);
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_os = '0; m_ptr = 0;
        end else if (!m_ov || bus.out_ready) begin
            g = m_grant(bus.mode, bus.in_valid, m_ptr);
            if (g != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (g[k]) begin
                        m_ov  = 1'b1;
                        m_od  = bus.in_data[k*W +: W];
                        m_os  = SW'(k);
                        m_ptr = (k + 1) % N;
                    end
                end
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d);
        bus.in_data[ch*W +: W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mode = 1'b1; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        bus.in_data = $urandom;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready); end
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel: got %0d expected 0", bus.out_sel); end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        bus.mode = 1'b0; bus.in_valid = 4'b1010; bus.out_ready = 1'b1;
        bus.in_data = $urandom;
        set_ch(1, 8'h11); set_ch(3, 8'h33);
        #1;
        checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready0: got %b expected 0010", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_sel !== 2'd1) begin
                errors++; $display("FAIL fixed_out[%0d]: got v=%b d=%h s=%0d expected v=1 d=11 s=1", i, bus.out_valid, bus.out_data, bus.out_sel);
            end
            checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, bus.in_ready); end
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 8'hA0 + 8'(c));
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(i % 4) || bus.out_data !== 8'hA0 + 8'(i % 4)) begin
                errors++; $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", i, bus.out_valid, bus.out_sel, bus.out_data, i % 4, 8'hA0 + 8'(i % 4));
            end
        end
    endtask

    task automatic test_backpressure();
        bus.mode = 1'b0; bus.in_valid = 4'b0001; bus.out_ready = 1'b1;
        set_ch(0, 8'h22);
        tick();
        set_ch(0, 8'h23); bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.out_sel !== 2'd0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=22 s=0", i, bus.out_valid, bus.out_data, bus.out_sel);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b expected 0001", bus.in_ready); end
        tick();
        checks++; if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h23) begin
            errors++; $display("FAIL bp_release_out: got s=%0d d=%h expected s=0 d=23", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_sparse_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 8'hC0 + 8'(c));
        bus.in_valid = 4'b0100;
        tick();
        checks++; if (bus.out_sel !== 2'd2) begin errors++; $display("FAIL sparse_first: got %0d expected 2", bus.out_sel); end
        bus.in_valid = 4'b0101;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL sparse_wrap_ready: got %b expected 0001", bus.in_ready); end
        tick();
        checks++; if (bus.out_sel !== 2'd0 || bus.out_data !== 8'hC0) begin errors++; $display("FAIL sparse_wrap_out: got s=%0d d=%h expected s=0 d=c0", bus.out_sel, bus.out_data); end
        bus.in_valid = 4'b0100;
        #1;
        checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL sparse_ch2_ready: got %b expected 0100", bus.in_ready); end
        tick();
        bus.in_valid = 4'b1111;
        #1;
        checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ptr3_ready: got %b expected 1000", bus.in_ready); end
        tick();
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL sparse_ptr_wrap0: got %b expected 0001", bus.in_ready); end
    endtask

    task automatic test_drain();
        bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'b0001;
        set_ch(0, 8'h5A);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin errors++; $display("FAIL drain_load: got v=%b d=%h expected v=1 d=5a", bus.out_valid, bus.out_data); end
        bus.in_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h5A || bus.out_sel !== 2'd0) begin
                errors++; $display("FAIL drain_empty[%0d]: got v=%b d=%h s=%0d expected v=0 d=5a s=0", i, bus.out_valid, bus.out_data, bus.out_sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'b0010;
        set_ch(1, 8'h77);
        tick();
        bus.out_ready = 1'b0; rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b expected 0000", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0) begin
            errors++; $display("FAIL rstmid_out: got v=%b d=%h s=%0d expected v=0 d=00 s=0", bus.out_valid, bus.out_data, bus.out_sel);
        end
        rst = 1'b0; bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_ready: got %b expected 0001", bus.in_ready); end
        tick();
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL rstmid_first_sel: got %0d expected 0", bus.out_sel); end
    endtask

    task automatic test_random();
        logic [N-1:0] hold;
        logic [N-1:0] exp_rdy;
        hold = '0;
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (!hold[ch]) begin
                    bus.in_valid[ch] = ($urandom_range(0, 1) == 1);
                    set_ch(ch, 8'($urandom));
                end
            end
            if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            exp_rdy = m_ready();
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.in_ready, exp_rdy); end
            hold = bus.in_valid & ~exp_rdy;
            tick();
            checks++; if (bus.out_valid !== m_ov || bus.out_data !== m_od || bus.out_sel !== m_os) begin
                errors++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", c, bus.out_valid, bus.out_data, bus.out_sel, m_ov, m_od, m_os);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_drain();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
